// File: rtl/clk_rst_gen.sv
// Behavioural clock and reset source for block-level benches (not synthesizable).
// Define CLK_RST_GEN_TRACE_EN to log every rising edge and every rst_n transition.
`timescale 1ns/1ps

module clk_rst_gen #(
    parameter realtime     ClkPeriod    = 10ns,
    parameter int unsigned RstClkCycles = 7,
    parameter int unsigned ClkDutyPct   = 50,
    parameter int unsigned CntWidth     = 32
) (
    output logic                clk,
    output logic                rst_n,
    input  logic                restart_req,
    input  logic                halt,
    output logic [CntWidth-1:0] cycle_cnt,
    output logic                rst_done
);

    localparam realtime HighTime = ClkPeriod * ClkDutyPct / 100.0;
    localparam realtime LowTime  = ClkPeriod - HighTime;

    // A restart edge is itself the first of the hold edges.
    localparam int unsigned RestartHold = (RstClkCycles > 1) ? RstClkCycles - 1 : 1;

`ifdef CLK_RST_GEN_TRACE_EN
    localparam bit TraceEn = 1'b1;
`else
    localparam bit TraceEn = 1'b0;
`endif

    if (RstClkCycles == 0) begin : g_bad_rst
        $fatal(1, "clk_rst_gen: RstClkCycles must be >= 1");
    end
    if (ClkPeriod <= 0.0) begin : g_bad_period
        $fatal(1, "clk_rst_gen: ClkPeriod must be > 0");
    end
    if (ClkDutyPct < 1 || ClkDutyPct > 99) begin : g_bad_duty
        $fatal(1, "clk_rst_gen: ClkDutyPct must be in 1..99");
    end

    logic                rst_q = 1'b0;
    logic [CntWidth-1:0] cnt_q = '0;
    int unsigned         hold_q = RstClkCycles;

    // Boundaries sit on the k*ClkPeriod grid; a halted boundary is simply skipped.
    initial begin
        clk = 1'b0;
        #(ClkPeriod);
        forever begin
            if (!halt) begin
                clk = 1'b1;
                #(HighTime);
                clk = 1'b0;
                #(LowTime);
            end else begin
                #(ClkPeriod);
            end
        end
    end

    always @(posedge clk) begin
        cnt_q <= cnt_q + CntWidth'(1);
        if (restart_req) begin
            rst_q  <= (RstClkCycles == 1) && rst_q;
            hold_q <= RestartHold;
        end else if (!rst_q) begin
            if (hold_q <= 1) begin
                rst_q  <= 1'b1;
                hold_q <= 0;
            end else begin
                hold_q <= hold_q - 1;
            end
        end
    end

    assign rst_n     = rst_q;
    assign rst_done  = rst_q;
    assign cycle_cnt = cnt_q;

    if (TraceEn) begin : g_trace
        always @(posedge clk) $info("clk_rst_gen: rise t=%0t cycle_cnt=%0d", $time, cnt_q);
        always @(rst_q)       $info("clk_rst_gen: rst_n=%0b t=%0t cycle_cnt=%0d", rst_q, $time, cnt_q);
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Randomized restart/halt stimulus against a period-grid reference model,
// plus a second instance covering duty cycle, single-cycle reset and counter wrap.
`timescale 1ns/1ps

module tb_clk_rst_gen;

    localparam int NRst = 7;
    localparam int NPer = 200;

    logic        clk, rst_n, rst_done;
    logic        restart_req, halt;
    logic [31:0] cycle_cnt;

    logic        clk2, rst_n2, rst_done2;
    logic [3:0]  cycle_cnt2;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    clk_rst_gen u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_req(restart_req),
        .halt       (halt),
        .cycle_cnt  (cycle_cnt),
        .rst_done   (rst_done)
    );

    clk_rst_gen #(
        .ClkPeriod   (20ns),
        .RstClkCycles(1),
        .ClkDutyPct  (25),
        .CntWidth    (4)
    ) u_dut2 (
        .clk        (clk2),
        .rst_n      (rst_n2),
        .restart_req(zero),
        .halt       (zero),
        .cycle_cnt  (cycle_cnt2),
        .rst_done   (rst_done2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_until(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    // Edge log for the main instance: every rise must land on the 10ns grid.
    realtime edge_t[$];
    int      off_grid = 0;
    always @(posedge clk) begin
        edge_t.push_back($realtime);
        if ($rtoi($realtime) % 10 != 0 || $realtime != $itor($rtoi($realtime))) off_grid++;
    end

    // Second instance: 20ns period, 25% duty, 1-cycle reset, 4-bit counter.
    initial begin
        zero = 1'b0;
        wait_until(19);
        chk("d2_clk_pre", clk2, 1'b0);
        chk("d2_rst_pre", rst_n2, 1'b0);
        wait_until(21);
        chk("d2_clk_hi", clk2, 1'b1);
        chk("d2_rst_up", rst_n2, 1'b1);
        chk("d2_done_up", rst_done2, 1'b1);
        chk("d2_cnt1", cycle_cnt2, 4'd1);
        wait_until(24.5);
        chk("d2_clk_hi_end", clk2, 1'b1);
        wait_until(25.5);
        chk("d2_clk_lo", clk2, 1'b0);
        wait_until(39.5);
        chk("d2_clk_lo_end", clk2, 1'b0);
        wait_until(16 * 20 + 1);
        chk("d2_cnt_wrap", cycle_cnt2, 4'd0);
        wait_until(17 * 20 + 1);
        chk("d2_cnt_after_wrap", cycle_cnt2, 4'd1);
    end

    // Reference: n = edges so far, last = edge index where the current reset
    // window started (edge 1 at power-up). rst_n is high once N edges of the
    // window have passed.
    initial begin
        int  n, last;
        bit  edge_now, exp_rst;
        realtime p;

        restart_req = 1'b0;
        halt        = 1'b0;
        n = 0;
        last = 1;
        exp_rst = 1'b0;

        wait_until(0.5);
        chk("rst_clk", clk, 1'b0);
        chk("rst_rst_n", rst_n, 1'b0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        chk("rst_done0", rst_done, 1'b0);

        for (int k = 1; k <= NPer; k++) begin
            p = 10.0 * k;

            wait_until(p - 2);
            if (k == 15)      restart_req = 1'b1;
            else if (k > 40)  restart_req = ($urandom_range(0, 11) == 0);
            else              restart_req = 1'b0;

            wait_until(p - 1);
            chk("pre_rst_n", rst_n, exp_rst);
            chk("pre_clk", clk, 1'b0);

            edge_now = !halt;
            if (edge_now) begin
                n++;
                if (restart_req) last = n;
                exp_rst = (n - last + 1) >= NRst;
            end

            wait_until(p + 1);
            chk("post_clk", clk, edge_now);
            chk("post_cnt", cycle_cnt, n);
            chk("post_rst_n", rst_n, exp_rst);
            chk("post_done", rst_done, exp_rst);

            wait_until(p + 2);
            if (k >= 25 && k <= 29) halt = 1'b1;
            else if (k > 40)        halt = ($urandom_range(0, 5) == 0);
            else                    halt = 1'b0;

            wait_until(p + 4);
            chk("hi_clk", clk, edge_now);
            wait_until(p + 6);
            chk("lo_clk", clk, 1'b0);
        end

        chk("edge_count", edge_t.size(), n);
        chk("off_grid", off_grid, 0);
        for (int i = 0; i < 12; i++)
            chk("first_edges", $rtoi(edge_t[i]), 10 * (i + 1));
        chk("halt_gap_edge", $rtoi(edge_t[24]), 250);
        chk("halt_resume_edge", $rtoi(edge_t[25]), 310);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
